// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: raster-order pixels in, one saturated
// gradient magnitude per interior pixel out, plus a frame-done pulse.
module sobel_stream #(
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int MAG_MODE = 0
) (
    input  logic              clk_i_s,
    input  logic              rstn_i_s,
    input  logic              en_i_s,
    input  logic              valid_i_s,
    input  logic [DATA_W-1:0] data_i_s,
    output logic              valid_o_s,
    output logic [DATA_W-1:0] data_o_s,
    output logic              sobel_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = DATA_W + 2;
    localparam int GW = DATA_W + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef logic [2:0][2:0][DATA_W-1:0] win_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic                   drain_q, drain_d;
    logic                   en_prev_q, en_prev_d;
    logic                   win_vld_q, win_vld_d;
    logic                   grad_vld_q, grad_vld_d;
    logic                   valid_o_q, valid_o_d;
    logic [DATA_W-1:0]      data_o_q, data_o_d;
    logic                   done_q, done_d;
    logic signed [GW-1:0]   gx_q, gx_d, gy_q, gy_d;
    win_t                   win_q, win_d;

    logic [DATA_W-1:0]      lb0_mem [IMG_W];
    logic [DATA_W-1:0]      lb1_mem [IMG_W];

    logic                   accept;
    logic                   abort;
    logic [AW-1:0]          abs_x, abs_y, max_xy;
    logic [AW:0]            mag_full;
    logic [DATA_W-1:0]      mag_sat;

    function automatic logic [AW-1:0] wsum(input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b,
                                           input logic [DATA_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        drain_d   = drain_q;
        en_prev_d = en_i_s;
        accept    = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i_s && !en_prev_q) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (!en_i_s) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else if (valid_i_s) begin
                    accept = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            drain_d = 1'b0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!en_i_s) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (drain_q) begin
                    state_d = DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    // New window column is (two lines up, one line up, incoming pixel) at this col.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_mem[col_q];
            win_d[1][2] = lb0_mem[col_q];
            win_d[2][2] = data_i_s;
        end
    end

    always_comb begin
        win_vld_d  = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
        grad_vld_d = win_vld_q && !abort;
        valid_o_d  = grad_vld_q && !abort;
        gx_d = gx_q;
        gy_d = gy_q;
        if (win_vld_q) begin
            gx_d = $signed({1'b0, wsum(win_q[0][2], win_q[1][2], win_q[2][2])})
                 - $signed({1'b0, wsum(win_q[0][0], win_q[1][0], win_q[2][0])});
            gy_d = $signed({1'b0, wsum(win_q[2][0], win_q[2][1], win_q[2][2])})
                 - $signed({1'b0, wsum(win_q[0][0], win_q[0][1], win_q[0][2])});
        end
    end

    // |G| never exceeds 4*(2^DATA_W-1), so AW bits hold either absolute value.
    always_comb begin
        abs_x    = gx_q[GW-1] ? AW'(-gx_q) : AW'(gx_q);
        abs_y    = gy_q[GW-1] ? AW'(-gy_q) : AW'(gy_q);
        max_xy   = (abs_x >= abs_y) ? abs_x : abs_y;
        mag_full = (MAG_MODE == 0) ? ({1'b0, abs_x} + {1'b0, abs_y}) : {1'b0, max_xy};
        mag_sat  = (|mag_full[AW:DATA_W]) ? '1 : mag_full[DATA_W-1:0];
        data_o_d = (grad_vld_q && !abort) ? mag_sat : data_o_q;
        done_d   = (state_q == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i_s or negedge rstn_i_s) begin
        if (!rstn_i_s) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            drain_q    <= 1'b0;
            en_prev_q  <= 1'b0;
            win_vld_q  <= 1'b0;
            grad_vld_q <= 1'b0;
            valid_o_q  <= 1'b0;
            data_o_q   <= '0;
            done_q     <= 1'b0;
            gx_q       <= '0;
            gy_q       <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            drain_q    <= drain_d;
            en_prev_q  <= en_prev_d;
            win_vld_q  <= win_vld_d;
            grad_vld_q <= grad_vld_d;
            valid_o_q  <= valid_o_d;
            data_o_q   <= data_o_d;
            done_q     <= done_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
        end
    end

    // NOTE: line buffers and window carry no reset; their contents are qualified by the valid chain.
    always_ff @(posedge clk_i_s) begin
        if (accept) begin
            lb1_mem[col_q] <= lb0_mem[col_q];
            lb0_mem[col_q] <= data_i_s;
        end
        win_q <= win_d;
    end

    assign valid_o_s  = valid_o_q;
    assign data_o_s   = data_o_q;
    assign sobel_done = done_q;

endmodule
